// File: rtl/next_pc_controller.sv
// ---------------------------------------------------------------------------
// next_pc_controller
//   Program-counter sequencer for the monocycle core. It owns the PC register
//   and runs a fetch/execute handshake with instruction memory. When the
//   datapath resolves the current instruction, it decides between the
//   sequential PC (pc + STEP) and the ALU target. The select it used is
//   reported on o_next_pc_src.
//
// Optional feature (macro NEXTPC_MISALIGN_TRAP_EN):
//   Defined   : a taken branch/jump to a target that is not word aligned
//               enters a TRAP state. The PC is held there until
//               i_trap_clear, then the PC skips the faulting instruction.
//   Undefined : the two low target bits are forced to zero when loaded,
//               there is no TRAP state, and o_trap/o_trap_addr read 0.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   o_fetch_req      instruction fetch request (high in FETCH)
//   o_fetch_addr     fetch address, always equal to the PC
//   i_fetch_ack      imem returned the instruction at o_fetch_addr
//   i_resolve_valid  datapath outcome for the current instruction is valid
//   i_branch         current instruction is a conditional branch
//   i_branch_cond    branch comparison result (1 = taken)
//   i_jump           current instruction is an unconditional jump
//   i_target         branch/jump target from the ALU
//   i_stall          hold the PC update while high
//   i_trap_clear     acknowledge and clear a misalignment trap
//   o_pc             current PC
//   o_pc_plus_step   pc + STEP, modulo 2^XLEN
//   o_next_pc_src    select used by the last PC update (1 = target)
//   o_trap           misaligned-target trap pending
//   o_trap_addr      offending target address
//   o_retire_cnt     retired instruction count (wraps)
// ---------------------------------------------------------------------------
module next_pc_controller #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     STEP         = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_fetch_req,
  output logic [XLEN-1:0] o_fetch_addr,
  input  logic            i_fetch_ack,
  input  logic            i_resolve_valid,
  input  logic            i_branch,
  input  logic            i_branch_cond,
  input  logic            i_jump,
  input  logic [XLEN-1:0] i_target,
  input  logic            i_stall,
  input  logic            i_trap_clear,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus_step,
  output logic            o_next_pc_src,
  output logic            o_trap,
  output logic [XLEN-1:0] o_trap_addr,
  output logic [31:0]     o_retire_cnt
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_TRAP  = 2'd3;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_next_pc_src;
  logic [31:0]     r_retire_cnt;

  logic            w_take;
  logic            w_resolve;
  logic            w_misalign;
  logic [XLEN-1:0] w_pc_plus_step;
  logic [XLEN-1:0] w_target_load;

  // A jump is always taken, whatever the branch inputs say.
  assign w_take         = i_jump | (i_branch & i_branch_cond);
  assign w_resolve      = (r_state == S_EXEC) & i_resolve_valid & ~i_stall;
  assign w_pc_plus_step = r_pc + XLEN'(STEP);

`ifdef NEXTPC_MISALIGN_TRAP_EN
  logic            r_trap;
  logic [XLEN-1:0] r_trap_addr;

  assign w_target_load = i_target;
  assign w_misalign    = w_take & (i_target[1:0] != 2'b00);

  // The trap flag and the captured address are set on the resolve edge of
  // a misaligned taken target. Only trap_clear in TRAP drops the flag. The
  // captured address stays until the next trap for post-mortem reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_trap      <= 1'b0;
      r_trap_addr <= '0;
    end else if (w_resolve && w_misalign) begin
      r_trap      <= 1'b1;
      r_trap_addr <= i_target;
    end else if ((r_state == S_TRAP) && i_trap_clear) begin
      r_trap      <= 1'b0;
    end
  end

  assign o_trap      = r_trap;
  assign o_trap_addr = r_trap_addr;
`else
  logic w_unused;

  // Without the trap, the low target bits are meaningless. Drop them so the
  // PC stays word aligned.
  assign w_target_load = {i_target[XLEN-1:2], 2'b00};
  assign w_misalign    = 1'b0;
  assign w_unused      = ^{i_trap_clear, i_target[1:0]};

  assign o_trap      = 1'b0;
  assign o_trap_addr = '0;
`endif

  // Main sequencer: BOOT -> FETCH -> EXEC -> FETCH ...
  // The PC, the mux select and the retire count all change on the single
  // resolve edge. A stalled resolve leaves everything untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_VECTOR;
      r_next_pc_src <= 1'b0;
      r_retire_cnt  <= '0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (i_fetch_ack) begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_resolve) begin
            if (w_misalign) begin
              r_state <= S_TRAP;
            end else begin
              r_next_pc_src <= w_take;
              r_pc          <= w_take ? w_target_load : w_pc_plus_step;
              r_retire_cnt  <= r_retire_cnt + 32'd1;
              r_state       <= S_FETCH;
            end
          end
        end
`ifdef NEXTPC_MISALIGN_TRAP_EN
        S_TRAP: begin
          // Skip the faulting instruction. It is not counted as retired.
          if (i_trap_clear) begin
            r_pc          <= w_pc_plus_step;
            r_next_pc_src <= 1'b0;
            r_state       <= S_FETCH;
          end
        end
`endif
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  assign o_fetch_req    = (r_state == S_FETCH);
  assign o_fetch_addr   = r_pc;
  assign o_pc           = r_pc;
  assign o_pc_plus_step = w_pc_plus_step;
  assign o_next_pc_src  = r_next_pc_src;
  assign o_retire_cnt   = r_retire_cnt;

endmodule

// File: tb/tb_next_pc_controller.sv
// ---------------------------------------------------------------------------
// tb_next_pc_controller
//   Directed bench for next_pc_controller. Two instances share the same
//   stimulus. Instance 0 uses the default reset vector of 0. Instance 1 boots
//   from 32'hFFFF_FFFC, so its first sequential step wraps to 0.
//   A behavioural model tracks the expected outputs of both instances. A
//   negedge process compares the DUTs against it every cycle. The stimulus
//   sequence also pins hand-computed values at key points.
//   Build with NEXTPC_MISALIGN_TRAP_EN defined to exercise the trap variant.
// ---------------------------------------------------------------------------
module tb_next_pc_controller;

`ifdef NEXTPC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk;
  logic        rstN;
  logic        fetchAck;
  logic        resolveValid;
  logic        branch;
  logic        branchCond;
  logic        jump;
  logic [31:0] target;
  logic        stall;
  logic        trapClear;

  logic        fetchReq   [2];
  logic [31:0] fetchAddr  [2];
  logic [31:0] pcOut      [2];
  logic [31:0] pcPlusStep [2];
  logic        nextPcSrc  [2];
  logic        trapOut    [2];
  logic [31:0] trapAddr   [2];
  logic [31:0] retireCnt  [2];

  int nChecks = 0;
  int nFails  = 0;

  next_pc_controller #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .STEP(4)) dut0 (
    .i_clk(clk), .i_rst_n(rstN),
    .o_fetch_req(fetchReq[0]), .o_fetch_addr(fetchAddr[0]),
    .i_fetch_ack(fetchAck), .i_resolve_valid(resolveValid),
    .i_branch(branch), .i_branch_cond(branchCond), .i_jump(jump),
    .i_target(target), .i_stall(stall), .i_trap_clear(trapClear),
    .o_pc(pcOut[0]), .o_pc_plus_step(pcPlusStep[0]),
    .o_next_pc_src(nextPcSrc[0]), .o_trap(trapOut[0]),
    .o_trap_addr(trapAddr[0]), .o_retire_cnt(retireCnt[0])
  );

  next_pc_controller #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFFC), .STEP(4)) dut1 (
    .i_clk(clk), .i_rst_n(rstN),
    .o_fetch_req(fetchReq[1]), .o_fetch_addr(fetchAddr[1]),
    .i_fetch_ack(fetchAck), .i_resolve_valid(resolveValid),
    .i_branch(branch), .i_branch_cond(branchCond), .i_jump(jump),
    .i_target(target), .i_stall(stall), .i_trap_clear(trapClear),
    .o_pc(pcOut[1]), .o_pc_plus_step(pcPlusStep[1]),
    .o_next_pc_src(nextPcSrc[1]), .o_trap(trapOut[1]),
    .o_trap_addr(trapAddr[1]), .o_retire_cnt(retireCnt[1])
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model. It tracks which phase of the handshake each
  // instruction is in, plus the architectural values the rules produce.
  typedef enum {phBoot, phFetch, phExec, phTrap} modelPhase;

  modelPhase   mPhase;
  logic [31:0] mPc [2];
  logic        mSrc;
  logic        mTrap;
  logic [31:0] mTrapAddr;
  logic [31:0] mRetire;
  logic        mTake;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mPhase    = phBoot;
      mPc[0]    = 32'h0000_0000;
      mPc[1]    = 32'hFFFF_FFFC;
      mSrc      = 1'b0;
      mTrap     = 1'b0;
      mTrapAddr = 32'h0;
      mRetire   = 32'h0;
    end else begin
      mTake = jump || (branch && branchCond);
      case (mPhase)
        phBoot:  mPhase = phFetch;
        phFetch: if (fetchAck) mPhase = phExec;
        phExec: begin
          if (resolveValid && !stall) begin
            if (TRAP_EN && mTake && (target % 4 != 0)) begin
              mTrap     = 1'b1;
              mTrapAddr = target;
              mPhase    = phTrap;
            end else begin
              mSrc = mTake;
              for (int k = 0; k < 2; k++)
                mPc[k] = mTake ? (target - (target % 4)) : mPc[k] + 32'd4;
              mRetire = mRetire + 32'd1;
              mPhase  = phFetch;
            end
          end
        end
        phTrap: begin
          if (trapClear) begin
            mTrap = 1'b0;
            mSrc  = 1'b0;
            for (int k = 0; k < 2; k++) mPc[k] = mPc[k] + 32'd4;
            mPhase = phFetch;
          end
        end
        default: mPhase = phBoot;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Compare every DUT output against the model on every falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("fetchReq%0d", k), {31'b0, fetchReq[k]},
                  {31'b0, mPhase == phFetch});
      checkOutput($sformatf("fetchAddr%0d", k), fetchAddr[k], mPc[k]);
      checkOutput($sformatf("pc%0d", k), pcOut[k], mPc[k]);
      checkOutput($sformatf("pcPlusStep%0d", k), pcPlusStep[k], mPc[k] + 32'd4);
      checkOutput($sformatf("nextPcSrc%0d", k), {31'b0, nextPcSrc[k]}, {31'b0, mSrc});
      checkOutput($sformatf("trap%0d", k), {31'b0, trapOut[k]}, {31'b0, mTrap});
      checkOutput($sformatf("trapAddr%0d", k), trapAddr[k], mTrapAddr);
      checkOutput($sformatf("retireCnt%0d", k), retireCnt[k], mRetire);
    end
  end

  // Drive one cycle's inputs. Returns 1 unit after the edge that consumed them.
  task automatic applyStimulus(input logic ack, input logic rv, input logic br,
                               input logic bc, input logic jmp, input logic [31:0] tgt,
                               input logic stl, input logic clr);
    fetchAck     = ack;
    resolveValid = rv;
    branch       = br;
    branchCond   = bc;
    jump         = jmp;
    target       = tgt;
    stall        = stl;
    trapClear    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic ack();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rstN = 1'b0;
    fetchAck = 1'b0; resolveValid = 1'b0; branch = 1'b0; branchCond = 1'b0;
    jump = 1'b0; target = 32'h0; stall = 1'b0; trapClear = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // T1: reset values, BOOT for one cycle, then FETCH at the reset vector.
    checkOutput("rst pc0", pcOut[0], 32'h0);
    checkOutput("rst pc1", pcOut[1], 32'hFFFF_FFFC);
    checkOutput("rst fetchReq", {31'b0, fetchReq[0]}, 32'd0);
    rstN = 1'b1;
    checkOutput("boot fetchReq", {31'b0, fetchReq[0]}, 32'd0);
    idle();
    checkOutput("t1 fetchReq", {31'b0, fetchReq[0]}, 32'd1);
    checkOutput("t1 fetchAddr", fetchAddr[0], 32'h0);

    // T2: sequential step. Instance 1 wraps from FFFF_FFFC to 0.
    ack();
    checkOutput("t2 exec fetchReq", {31'b0, fetchReq[0]}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t2 pc", pcOut[0], 32'h4);
    checkOutput("t2 src", {31'b0, nextPcSrc[0]}, 32'd0);
    checkOutput("t2 retire", retireCnt[0], 32'd1);
    checkOutput("t2 fetchAddr", fetchAddr[0], 32'h4);
    checkOutput("t4 wrap pc1", pcOut[1], 32'h0);

    // Wait states, and a resolve_valid during FETCH that must be ignored.
    idle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
    checkOutput("fetch ignores resolve", pcOut[0], 32'h4);
    ack();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("seq pc8", pcOut[0], 32'h8);

    // T3: taken branch, then a not-taken branch from pc=8.
    ack();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 1'b0, 1'b0);
    checkOutput("t3 taken pc", pcOut[0], 32'h40);
    checkOutput("t3 taken src", {31'b0, nextPcSrc[0]}, 32'd1);
    ack();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 1'b0);
    checkOutput("jump back pc", pcOut[0], 32'h8);
    ack();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 1'b0);
    checkOutput("t3 nottaken pc", pcOut[0], 32'hC);
    checkOutput("t3 nottaken src", {31'b0, nextPcSrc[0]}, 32'd0);
    checkOutput("t3 retire", retireCnt[0], 32'd5);

    // T4: three stalled resolve cycles hold the PC. fetch_ack in EXEC is ignored.
    ack();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
    checkOutput("t4 stall pc", pcOut[0], 32'hC);
    checkOutput("t4 stall retire", retireCnt[0], 32'd5);
    checkOutput("t4 stall fetchReq", {31'b0, fetchReq[0]}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
    checkOutput("t4 release pc", pcOut[0], 32'h100);

    // A jump wins even when the branch inputs say not taken.
    ack();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
    checkOutput("jump priority pc", pcOut[0], 32'h200);
    checkOutput("jump priority src", {31'b0, nextPcSrc[0]}, 32'd1);

    // T5: jump to a misaligned target.
    ack();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h42, 1'b0, 1'b0);
`ifdef NEXTPC_MISALIGN_TRAP_EN
    checkOutput("t5 trap", {31'b0, trapOut[0]}, 32'd1);
    checkOutput("t5 trapAddr", trapAddr[0], 32'h42);
    checkOutput("t5 trap pc", pcOut[0], 32'h200);
    checkOutput("t5 trap retire", retireCnt[0], 32'd7);
    idle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
    checkOutput("t5 trap fetchReq", {31'b0, fetchReq[0]}, 32'd0);
    checkOutput("t5 trap held pc", pcOut[0], 32'h200);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("t5 clear pc", pcOut[0], 32'h204);
    checkOutput("t5 clear trap", {31'b0, trapOut[0]}, 32'd0);
    checkOutput("t5 clear fetchReq", {31'b0, fetchReq[0]}, 32'd1);
`else
    checkOutput("t5 aligned pc", pcOut[0], 32'h40);
    checkOutput("t5 no trap", {31'b0, trapOut[0]}, 32'd0);
    checkOutput("t5 src", {31'b0, nextPcSrc[0]}, 32'd1);
    checkOutput("t5 retire", retireCnt[0], 32'd8);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("t5 clear ignored pc", pcOut[0], 32'h40);
`endif

    // T6: async reset in the middle of FETCH, with fetch_ack pending.
    fetchAck = 1'b1;
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t6 fetchReq", {31'b0, fetchReq[0]}, 32'd0);
    checkOutput("t6 pc0", pcOut[0], 32'h0);
    checkOutput("t6 pc1", pcOut[1], 32'hFFFF_FFFC);
    checkOutput("t6 retire", retireCnt[0], 32'd0);
    checkOutput("t6 src", {31'b0, nextPcSrc[0]}, 32'd0);
    @(posedge clk);
    #1;
    fetchAck = 1'b0;
    rstN = 1'b1;
    idle();
    ack();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("post-reset pc", pcOut[0], 32'h4);
    checkOutput("post-reset retire", retireCnt[0], 32'd1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
